// File: rtl/select_adder_accumulator_if.sv
// Operand, adder and result handshakes of select_adder_accumulator.
// slave is the accumulator side; master is the surrounding parent.
interface select_adder_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sub;
  logic             in_last;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_sub, in_last,
    input  add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
    output out_valid, out_sum, out_ovf, out_count
  );

  modport master (
    output in_valid, in_data, in_sub, in_last,
    output add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
    input  out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/select_adder_accumulator.sv
// Accumulating front/back end around an external carry-select adder.
// One operand per two cycles; result offered on a valid/ready handshake.
module select_adder_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic                        Clk,
  input logic                        Reset_n,
  select_adder_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             last_reg;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             clear;
  logic             carry;

  assign accept = bus.in_valid & in_ready;
  assign clear  = out_valid & bus.out_ready;
  // carry-out on add; missing carry means borrow on subtract
  assign carry  = sub_reg ? ~bus.add_cout : bus.add_cout;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = last_reg ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      last_reg <= 1'b0;
      ovf      <= 1'b0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // a_reg mirrors acc through EXEC and holds it afterwards
        a_reg    <= acc;
        b_reg    <= bus.in_sub ? ~bus.in_data : bus.in_data;
        sub_reg  <= bus.in_sub;
        last_reg <= bus.in_last;
        if (count != '1) count <= count + CNT_W'(1);
      end
      if (state == EXEC) begin
        acc <= bus.add_s;
        ovf <= ovf | carry;
      end
      if (clear) begin
        acc   <= '0;
        ovf   <= 1'b0;
        count <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.out_count = count;
  assign bus.add_a     = a_reg;
  assign bus.add_b     = b_reg;
  assign bus.add_cin   = sub_reg;
endmodule

// File: tb/tb_select_adder_accumulator.sv
// Bench for select_adder_accumulator with a behavioural adder and a
// word-level arithmetic reference model.
module tb_select_adder_accumulator;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  int   m_acc = 0;
  bit   m_ovf = 0;
  int   m_cnt = 0;

  select_adder_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  select_adder_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // the parent's combinational adder
  always_comb
    {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                              + {16'd0, bus.add_cin};

  function automatic void model_clear();
    m_acc = 0;
    m_ovf = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] d, input logic s);
    int v;
    v = int'(d);
    if (s) begin
      if (v > m_acc) m_ovf = 1;
      m_acc = (m_acc - v + 65536) % 65536;
    end else begin
      if (m_acc + v > 65535) m_ovf = 1;
      m_acc = (m_acc + v) % 65536;
    end
    if (m_cnt < 255) m_cnt = m_cnt + 1;
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_word(input logic [15:0] d, input logic s,
                           input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    bus.in_last  = l;
    while (!bus.in_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    n_tests++;
    if (!bus.in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      @(posedge Clk);
      model_accept(d, s);
    end
    @(negedge Clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [15:0] s, output logic o,
                            output logic [7:0] c, output bit ok);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    ok = bus.out_valid;
    s  = bus.out_sum;
    o  = bus.out_ovf;
    c  = bus.out_count;
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
    n_tests++;
    if ({bus.out_sum, bus.out_ovf, bus.out_count} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_out: sum=%h ovf=%b cnt=%0d required 0",
               bus.out_sum, bus.out_ovf, bus.out_count);
    end
    n_tests++;
    if ({bus.add_a, bus.add_b, bus.add_cin} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_add: a=%h b=%h cin=%b required 0",
               bus.add_a, bus.add_b, bus.add_cin);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
    model_clear();
  endtask

  task automatic test_basic_add();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    send_word(16'h0003, 1'b0, 1'b0);
    send_word(16'h0004, 1'b0, 1'b1);
    n_tests++;
    if (bus.add_a !== 16'h0003 || bus.add_b !== 16'h0004 ||
        bus.add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_exec: a=%h b=%h cin=%b required 0003 0004 0",
               bus.add_a, bus.add_b, bus.add_cin);
    end
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'(m_acc) || o !== m_ovf || c !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL basic_result: ok=%b sum=%h ovf=%b cnt=%0d required %h %b %0d",
               ok, s, o, c, 16'(m_acc), m_ovf, m_cnt);
    end
    @(negedge Clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: out_valid=%b required 0", bus.out_valid);
    end
    model_clear();
  endtask

  task automatic test_wrap();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    send_word(16'hFFFF, 1'b0, 1'b0);
    send_word(16'h0002, 1'b0, 1'b1);
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'h0001 || o !== 1'b1 || c !== 8'd2) begin
      n_fail++;
      $display("FAIL wrap_result: ok=%b sum=%h ovf=%b cnt=%0d required 0001 1 2",
               ok, s, o, c);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_sub();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    send_word(16'h0010, 1'b0, 1'b0);
    send_word(16'h0001, 1'b1, 1'b1);
    n_tests++;
    if (bus.add_b !== 16'hFFFE || bus.add_cin !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_exec: b=%h cin=%b required fffe 1",
               bus.add_b, bus.add_cin);
    end
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'h000F || o !== 1'b0 || c !== 8'd2) begin
      n_fail++;
      $display("FAIL sub_result: ok=%b sum=%h ovf=%b cnt=%0d required 000f 0 2",
               ok, s, o, c);
    end
    @(negedge Clk);
    model_clear();
    send_word(16'h0001, 1'b1, 1'b1);
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'hFFFF || o !== 1'b1 || c !== 8'd1) begin
      n_fail++;
      $display("FAIL sub_borrow: ok=%b sum=%h ovf=%b cnt=%0d required ffff 1 1",
               ok, s, o, c);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    bus.out_ready = 1'b0;
    send_word(16'h1234, 1'b0, 1'b1);
    get_result(s, o, c, ok);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h1234 ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b sum=%h in_ready=%b required 1 1234 0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready);
      end
      @(negedge Clk);
    end
    bus.out_ready = 1'b1;
    @(negedge Clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
    model_clear();
    send_word(16'h0001, 1'b0, 1'b1);
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'h0001 || o !== 1'b0 || c !== 8'd1) begin
      n_fail++;
      $display("FAIL stall_clear: ok=%b sum=%h ovf=%b cnt=%0d required 0001 0 1",
               ok, s, o, c);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[4];
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    bit          gap_bad;
    int          idx;
    int          last_hs;
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom_range(0, 16'h3FFF));
    idx = 0;
    last_hs = -1;
    gap_bad = 0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 40 && idx < 4; n++) begin
      if (bus.in_ready) begin
        bus.in_data = w[idx];
        bus.in_sub  = 1'b0;
        bus.in_last = (idx == 3);
        @(posedge Clk);
        model_accept(w[idx], 1'b0);
        if (last_hs >= 0 && n - last_hs != 2) gap_bad = 1;
        last_hs = n;
        idx++;
      end else begin
        bus.in_data = 16'($urandom);
        bus.in_sub  = 1'($urandom);
        bus.in_last = 1'($urandom);
        @(posedge Clk);
      end
      @(negedge Clk);
      if (idx == 4) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (idx != 4 || gap_bad) begin
      n_fail++;
      $display("FAIL b2b_rate: words=%0d gap_bad=%b required 4 0", idx, gap_bad);
    end
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'(m_acc) || o !== m_ovf || c !== 8'd4) begin
      n_fail++;
      $display("FAIL b2b_result: ok=%b sum=%h ovf=%b cnt=%0d required %h %b 4",
               ok, s, o, c, 16'(m_acc), m_ovf);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_saturate();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    for (int i = 0; i < 300; i++) send_word(16'h0001, 1'b0, i == 299);
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'h012C || o !== 1'b0 || c !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL sat_result: ok=%b sum=%h ovf=%b cnt=%0d required 012c 0 %0d",
               ok, s, o, c, m_cnt);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_async_reset();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    send_word(16'h0007, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.add_b !== 16'h0 || bus.add_a !== 16'h0 ||
        bus.out_count !== 8'd0 || bus.out_sum !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b a=%h b=%h cnt=%0d sum=%h required 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.add_a, bus.add_b,
               bus.out_count, bus.out_sum);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    @(negedge Clk);
    send_word(16'h0005, 1'b0, 1'b1);
    get_result(s, o, c, ok);
    n_tests++;
    if (!ok || s !== 16'h0005 || o !== 1'b0 || c !== 8'd1) begin
      n_fail++;
      $display("FAIL async_after: ok=%b sum=%h ovf=%b cnt=%0d required 0005 0 1",
               ok, s, o, c);
    end
    @(negedge Clk);
    model_clear();
  endtask

  task automatic test_random();
    logic [15:0] s;
    logic        o;
    logic [7:0]  c;
    bit          ok;
    int          len;
    int          stall;
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      for (int i = 0; i < len; i++)
        send_word(16'($urandom), 1'($urandom), i == len - 1);
      get_result(s, o, c, ok);
      repeat (stall) @(negedge Clk);
      n_tests++;
      if (!ok || bus.out_sum !== 16'(m_acc) || bus.out_ovf !== m_ovf ||
          bus.out_count !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand[%0d]: ok=%b sum=%h ovf=%b cnt=%0d required %h %b %0d",
                 k, ok, bus.out_sum, bus.out_ovf, bus.out_count,
                 16'(m_acc), m_ovf, m_cnt);
      end
      bus.out_ready = 1'b1;
      @(negedge Clk);
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_drain[%0d]: valid=%b in_ready=%b required 0 1",
                 k, bus.out_valid, bus.in_ready);
      end
      model_clear();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    Reset_n       = 1'b0;
    repeat (3) @(negedge Clk);
    test_reset();
    test_basic_add();
    test_wrap();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/select_adder_accumulator.md
Name: select_adder_accumulator

Overview:
- Sequential front/back end for the 16-bit carry-select adder: accepts a stream of 16-bit operands over a valid/ready handshake and drives the adder's A, B and cin.
- Captures the adder's S and cout back into a running accumulator, then presents the final sum, sticky overflow flag and word count on an output handshake.
- Sits directly around the adder instance: upstream (operand/carry-in source) and downstream (sum/carry sink). The adder is instantiated by the parent, not inside this block.

Parameters:
WIDTH, 16, datapath width; must equal the adder width.
CNT_W, 8, width of the accepted-word counter.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand word valid.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  operand word.
in_sub  input  1  1 = subtract in_data from the accumulator; 0 = add.
in_last  input  1  marks the final word of a sequence.
add_a  output  WIDTH  to adder A.
add_b  output  WIDTH  to adder B.
add_cin  output  1  to adder cin.
add_s  input  WIDTH  from adder S.
add_cout  input  1  from adder cout.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  final accumulator value.
out_ovf  output  1  sticky unsigned carry/borrow seen during the sequence.
out_count  output  CNT_W  number of words accumulated.

Behaviour:
- Reset (Reset_n = 0, asynchronous): state = IDLE; acc, b_reg, sub_reg, last_reg, ovf, count all 0.
- Reset outputs: in_ready = 1, out_valid = 0, out_sum = 0, out_ovf = 0, out_count = 0, add_a = 0, add_b = 0, add_cin = 0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: b_reg <= sub ? ~in_data : in_data; sub_reg <= in_sub; last_reg <= in_last; count <= count + 1, saturating at 2^CNT_W - 1; go to EXEC.
- EXEC:
  - in_ready = 0.
  - Drive add_a = acc, add_b = b_reg, add_cin = sub_reg for the whole cycle; the adder is combinational and settles within the cycle.
  - At the clock edge: acc <= add_s.
  - ovf <= ovf | (sub_reg ? ~add_cout : add_cout), i.e. carry-out on add, borrow on subtract.
  - Next state: DONE if last_reg, else IDLE.
- DONE:
  - in_ready = 0; out_valid = 1.
  - out_sum = acc, out_ovf = ovf, out_count = count; all held stable while out_valid & ~out_ready.
  - On out_ready: acc, ovf, count <= 0; go to IDLE.
- Outside EXEC, add_a/add_b/add_cin hold the last driven values; S is ignored.
- Throughput: at most one word per 2 cycles.
- Latency: last word accepted at edge N; out_valid asserted after edge N+1.
- Arithmetic:
  - Modulo 2^WIDTH; the sum wraps and only ovf records it.
  - Subtraction is two's complement via ~B with cin = 1.
  - in_sub on the first word subtracts from 0; 0 - 1 gives 0xFFFF with ovf = 1.
- in_data, in_sub and in_last are sampled only on a handshake. in_valid while in_ready = 0 is ignored; the source must hold it.
- A single word with in_last = 1 is a valid one-word sequence.
- Counter saturates: once count reaches 255 it stays at 255 until cleared.
- Reset mid-sequence (any state) returns immediately to the reset values, and any pending result is discarded.
- out_ready while out_valid = 0 has no effect.

Test Plan:
- Words 0x0003, 0x0004 (last), both add, out_ready = 1 -> out_sum = 0x0007, out_ovf = 0, out_count = 2; out_valid high exactly 1 cycle; add_a = 0x0003, add_b = 0x0004, add_cin = 0 during the second EXEC.
- 0xFFFF then 0x0002 (last), add -> out_sum = 0x0001, out_ovf = 1, out_count = 2.
- 0x0010 add, then 0x0001 sub (last) -> add_b = 0xFFFE, add_cin = 1 in the second EXEC; out_sum = 0x000F, out_ovf = 0. Separately, a single sub of 0x0001 -> out_sum = 0xFFFF, out_ovf = 1, out_count = 1.
- Result 0x1234 ready, out_ready held low 5 cycles -> out_valid and out_sum stable all 5 cycles, in_ready = 0. Release out_ready -> next cycle IDLE, in_ready = 1, and a new word 0x0001 (last) yields 0x0001, proving the clear.
- in_valid held high continuously with 4 words -> handshakes occur only every other cycle; any in_data change while in_ready = 0 is not captured; 300 one-valued words -> out_count = 255, out_sum = 0x012C.
- Reset_n pulsed low mid-EXEC (asynchronously, between edges) -> outputs go to reset values immediately; the following sequence 0x0005 (last) -> out_sum = 0x0005, out_count = 1.
